// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-way channel selector with manual select and
// timed auto-scan. In scan mode each channel is presented for DWELL cycles
// and a one-cycle wrap pulse marks the return from the last channel to 0.
module chan_scan_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          s,
    input  logic                      hold,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          o,
    output logic [SEL_W-1:0]          ch,
    output logic [CHANNELS-1:0]       en,
    output logic                      wrap
);

    // The dwell counter is wide enough for the largest legal DWELL (65535).
    localparam int                CNT_W      = 16;
    localparam logic [SEL_W:0]    CHAN_N     = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);

    logic [WIDTH-1:0]    din_arr [CHANNELS];

    logic [SEL_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    o_q, o_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic                wrap_q, wrap_d;

    // Unpack the flattened channel bus so the data mux is a plain array index.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign din_arr[k] = din[k*WIDTH +: WIDTH];
    end

    // Next-state: pick the channel (manual load or scan advance), then derive
    // the data word and one-hot enable from that same next channel.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // branches below leaves one unassigned and infers a latch.
        ch_d   = ch_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        en_d   = '0;

        if (!mode) begin
            // Manual: out-of-range selects keep the current channel.
            cnt_d = '0;
            if ({1'b0, s} < CHAN_N) begin
                ch_d = s;
            end
        end else if (!hold) begin
            if (cnt_q == DWELL_LAST) begin
                cnt_d = '0;
                if (ch_q == LAST_CH) begin
                    ch_d   = '0;
                    wrap_d = 1'b1;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Data and enable follow ch_d so o always matches the ch it lands with.
        o_d        = din_arr[ch_d];
        en_d[ch_d] = 1'b1;
    end

    // State registers with synchronous reset to channel 0.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            ch_q   <= '0;
            cnt_q  <= '0;
            o_q    <= '0;
            en_q   <= CHANNELS'(1);
            wrap_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            cnt_q  <= cnt_d;
            o_q    <= o_d;
            en_q   <= en_d;
            wrap_q <= wrap_d;
        end
    end

    assign o    = o_q;
    assign ch   = ch_q;
    assign en   = en_q;
    assign wrap = wrap_q;

endmodule

// File: doc/chan_scan_mux.md
CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning data width per channel.
REQ-002 The module SHALL have parameter CHANNELS, default 8, meaning number of input channels (legal range 2..16).
REQ-003 The module SHALL have parameter SEL_W, default 3, meaning select/index width, equal to ceil(log2(CHANNELS)).
REQ-004 The module SHALL have parameter DWELL, default 4, meaning clock cycles spent on each channel in scan mode (legal range 1..65535).
REQ-005 The module SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have a port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have a port mode, input, 1 bit: 0 = manual select, 1 = auto-scan.
REQ-008 The module SHALL have a port s, input, SEL_W bits: manual channel select.
REQ-009 The module SHALL have a port hold, input, 1 bit: freezes the scan position in auto-scan mode.
REQ-010 The module SHALL have a port din, input, CHANNELS*WIDTH bits: flattened inputs, with channel k at bits [k*WIDTH +: WIDTH].
REQ-011 The module SHALL have a port o, output, WIDTH bits: registered selected data.
REQ-012 The module SHALL have a port ch, output, SEL_W bits: registered index of the channel currently presented on o.
REQ-013 The module SHALL have a port en, output, CHANNELS bits: registered one-hot of ch.
REQ-014 The module SHALL have a port wrap, output, 1 bit: one-cycle pulse when the scan returns from channel CHANNELS-1 to channel 0.

Function
REQ-015 Every output SHALL be registered, with no combinational path from any input to any output.
REQ-016 o SHALL equal the channel of din indexed by ch, sampled on the same edge that ch takes that value (latency 1 from din/s to o).
REQ-017 en SHALL equal 1<<ch at all times after reset, and exactly one bit of en SHALL be high.
REQ-018 In manual mode (mode=0), on each edge ch SHALL load s and the dwell counter SHALL clear to 0.
REQ-019 In manual mode, wrap SHALL be 0.
REQ-020 In manual mode, if s >= CHANNELS, ch SHALL keep its previous value and o SHALL refresh from that channel.
REQ-021 In scan mode (mode=1, hold=0), the dwell counter SHALL count 0..DWELL-1.
REQ-022 In scan mode, on the edge where the counter equals DWELL-1, the counter SHALL return to 0 and ch SHALL advance by 1.
REQ-023 In scan mode, ch SHALL wrap from CHANNELS-1 to 0.
REQ-024 wrap SHALL be 1 for exactly the cycle in which ch becomes 0 through a scan wrap, and 0 otherwise.
REQ-025 With DWELL=1, ch SHALL advance every cycle.
REQ-026 In scan mode with hold=1, the counter and ch SHALL freeze, o SHALL keep refreshing from the current channel each cycle, and wrap SHALL be 0.
REQ-027 hold SHALL have no effect in manual mode.
REQ-028 On a manual-to-scan transition, scanning SHALL start from the current ch with the counter at 0, so the first advance occurs DWELL cycles later.
REQ-029 On a scan-to-manual transition, ch SHALL load s on the first manual edge.
REQ-030 The index arithmetic SHALL be SEL_W bits wide, and ch SHALL never take a value >= CHANNELS, including when CHANNELS is not a power of 2.

Reset
REQ-031 When rst=1 at an edge, the module SHALL set o=0, ch=0, en=1 (bit 0), wrap=0 and dwell counter=0, with rst taking priority over mode, hold and s.
REQ-032 Reset asserted mid-dwell or mid-scan SHALL abort the scan, and after rst is released the first scan advance SHALL occur DWELL cycles later, starting from channel 0.

Verification
REQ-033 The bench SHALL cover manual sweep: defaults, din channel k = {16'hAA55 or 16'h55AA alternating, 16'hkkkk}, mode=0, s stepped 0..7 every 5 cycles -> one cycle after each step, o = 32'hAA550000, 32'h55AA1111, ... 32'h55AA7777, ch=s, en=1<<s.
REQ-034 The bench SHALL cover scan with wrap: mode=1, DWELL=4, start ch=0 -> ch advances every 4 cycles through 0..7,0; wrap high for exactly 1 cycle at the 7->0 transition (cycle 32 after scan start); o tracks the channel data.
REQ-035 The bench SHALL cover hold: during scan at ch=3, hold=1 for 10 cycles while din ch3 changes to 32'h12345678 -> ch stays 3, o = 32'h12345678 one cycle after the change, no wrap; after hold=0, ch=4 after the remaining dwell cycles.
REQ-036 The bench SHALL cover out-of-range select: CHANNELS=6 (SEL_W=3), manual s=5 then s=7 -> ch stays 5, o = channel 5 data; in scan, ch goes 5 -> 0 with wrap=1 and never reaches 6 or 7.
REQ-037 The bench SHALL cover reset mid-scan: rst pulsed 1 cycle at ch=6, counter=2 -> next cycle o=0, ch=0, en=8'h01, wrap=0; ch=1 appears 4 cycles after rst is released.
REQ-038 The bench SHALL cover mode switch: manual s=2 then mode=1 -> ch stays 2 for 4 cycles then goes to 3; mode=0 with s=6 -> ch=6 on the next edge.
